// File: rtl/reg_bank_responder.sv
// reg_bank_responder: terminating responder for the req/ack register bus.
// Holds NUM_RW_REGS software read/write registers followed by NUM_CNTRS
// saturating hardware event counters (read-only, any write clears).
// Exactly one ack per request, with ACK_DELAY extra cycles of ack latency.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   reg_req           request, held until after ack is seen
//   reg_rd_wr_L       1 = read, 0 = write
//   reg_addr          word address
//   reg_wr_data       write data
//   reg_ack           single-cycle acknowledge
//   reg_rd_data       read data, valid in the ack cycle
//   rw_regs           flattened control registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cntr_inc          per-counter increment pulses
module reg_bank_responder #(
    parameter int unsigned ADDR_WIDTH  = 22,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_RW_REGS = 8,
    parameter int unsigned NUM_CNTRS   = 8,
    parameter int unsigned CNTR_WIDTH  = 32,
    parameter int unsigned ACK_DELAY   = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              reg_req,
    input  logic                              reg_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0]             reg_addr,
    input  logic [DATA_WIDTH-1:0]             reg_wr_data,
    output logic                              reg_ack,
    output logic [DATA_WIDTH-1:0]             reg_rd_data,
    output logic [NUM_RW_REGS*DATA_WIDTH-1:0] rw_regs,
    input  logic [NUM_CNTRS-1:0]              cntr_inc
);

    localparam int unsigned DLY_W = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DELAY    = 2'd1;
    localparam logic [1:0] ST_ACK      = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [DLY_W-1:0]      dly_cnt;
    logic [DLY_W-1:0]      dly_nxt;

    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_rd;
    logic [DATA_WIDTH-1:0] cap_wr_data;

    logic [DATA_WIDTH-1:0] rw_q   [NUM_RW_REGS];
    logic [CNTR_WIDTH-1:0] cntr_q [NUM_CNTRS];

    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_rd;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [NUM_RW_REGS-1:0] rw_we;
    logic [NUM_CNTRS-1:0]   cntr_clr;

    // State register and delay counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_nxt;
        end
    end

    // Next-state logic; a dropped request during DELAY aborts silently
    always_comb begin
        state_nxt = state;
        dly_nxt   = dly_cnt;
        case (state)
            ST_IDLE: begin
                if (reg_req) begin
                    if (ACK_DELAY == 0) begin
                        state_nxt = ST_ACK;
                    end else begin
                        state_nxt = ST_DELAY;
                        dly_nxt   = DLY_W'(ACK_DELAY);
                    end
                end
            end
            ST_DELAY: begin
                if (!reg_req) begin
                    state_nxt = ST_IDLE;
                end else if (dly_cnt <= DLY_W'(1)) begin
                    state_nxt = ST_ACK;
                end else begin
                    dly_nxt = dly_cnt - DLY_W'(1);
                end
            end
            ST_ACK: begin
                state_nxt = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!reg_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_addr    <= '0;
            cap_rd      <= 1'b0;
            cap_wr_data <= '0;
        end else if (state == ST_IDLE && reg_req) begin
            cap_addr    <= reg_addr;
            cap_rd      <= reg_rd_wr_L;
            cap_wr_data <= reg_wr_data;
        end
    end

    // With zero delay the read is sampled on the capture edge, so use the live bus
    assign acc_addr = (state == ST_IDLE) ? reg_addr : cap_addr;
    assign acc_rd   = (state == ST_IDLE) ? reg_rd_wr_L : cap_rd;

    // Read mux; unmapped addresses return the DEADBEEF marker
    always_comb begin
        rd_mux = DATA_WIDTH'(32'hDEADBEEF);
        for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
            if (acc_addr == ADDR_WIDTH'(i)) begin
                rd_mux = rw_q[i];
            end
        end
        for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
            if (acc_addr == ADDR_WIDTH'(NUM_RW_REGS + i)) begin
                rd_mux = DATA_WIDTH'(cntr_q[i]);
            end
        end
    end

    // Write decode, active only in the ACK cycle of a write
    always_comb begin
        rw_we    = '0;
        cntr_clr = '0;
        if (state == ST_ACK && !cap_rd) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (cap_addr == ADDR_WIDTH'(i)) begin
                    rw_we[i] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
                if (cap_addr == ADDR_WIDTH'(NUM_RW_REGS + i)) begin
                    cntr_clr[i] = 1'b1;
                end
            end
        end
    end

    // Ack and read data registered on the edge entering ACK
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_ack     <= 1'b0;
            reg_rd_data <= '0;
        end else begin
            reg_ack <= (state_nxt == ST_ACK);
            if (state_nxt == ST_ACK && acc_rd) begin
                reg_rd_data <= rd_mux;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                rw_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (rw_we[i]) begin
                    rw_q[i] <= cap_wr_data;
                end
            end
        end
    end

    // Saturating event counters; a clearing write beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
                cntr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CNTRS; i++) begin
                if (cntr_clr[i]) begin
                    cntr_q[i] <= '0;
                end else if (cntr_inc[i] && (cntr_q[i] != '1)) begin
                    cntr_q[i] <= cntr_q[i] + CNTR_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_flat
        assign rw_regs[g*DATA_WIDTH +: DATA_WIDTH] = rw_q[g];
    end

endmodule

// File: tb/tb_reg_bank_responder.sv
// Testbench for reg_bank_responder: directed vectors against two instances,
// A (ACK_DELAY=0, 32-bit counters) and B (ACK_DELAY=10, 4-bit counters).
module tb_reg_bank_responder;

    logic         clk;
    logic         reset;

    logic         a_req, a_rd, a_ack;
    logic [21:0]  a_addr;
    logic [31:0]  a_wr, a_rd_data;
    logic [255:0] a_rw;
    logic [7:0]   a_inc;

    logic         b_req, b_rd, b_ack;
    logic [21:0]  b_addr;
    logic [31:0]  b_wr, b_rd_data;
    logic [255:0] b_rw;
    logic [7:0]   b_inc;

    int n_pass  = 0;
    int n_total = 0;

    reg_bank_responder u_a (
        .clk(clk), .reset(reset),
        .reg_req(a_req), .reg_rd_wr_L(a_rd), .reg_addr(a_addr), .reg_wr_data(a_wr),
        .reg_ack(a_ack), .reg_rd_data(a_rd_data), .rw_regs(a_rw), .cntr_inc(a_inc)
    );

    reg_bank_responder #(.CNTR_WIDTH(4), .ACK_DELAY(10)) u_b (
        .clk(clk), .reset(reset),
        .reg_req(b_req), .reg_rd_wr_L(b_rd), .reg_addr(b_addr), .reg_wr_data(b_wr),
        .reg_ack(b_ack), .reg_rd_data(b_rd_data), .rw_regs(b_rw), .cntr_inc(b_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance sel (0 = A, 1 = B); holds req `hold`
    // cycles past the ack. lat is cycles from request to first ack (-1 if none).
    task automatic bus_access(input bit sel, input bit rd, input logic [21:0] addr,
                              input logic [31:0] wd, input int hold,
                              output logic [31:0] rdata, output int nack,
                              output int lat, output logic [255:0] rw_next);
        logic ack;
        nack    = 0;
        lat     = -1;
        rdata   = '0;
        rw_next = '0;
        if (sel) begin b_req = 1; b_rd = rd; b_addr = addr; b_wr = wd; end
        else     begin a_req = 1; a_rd = rd; a_addr = addr; a_wr = wd; end
        for (int c = 1; c <= 40; c++) begin
            tick();
            ack = sel ? b_ack : a_ack;
            if (ack) begin
                nack++;
                if (lat < 0) begin
                    lat   = c;
                    rdata = sel ? b_rd_data : a_rd_data;
                end
            end
            if (lat >= 0 && c == lat + 1) rw_next = sel ? b_rw : a_rw;
            if (lat >= 0 && c >= lat + hold) break;
        end
        if (sel) b_req = 0; else a_req = 0;
        tick();
        if ((sel ? b_ack : a_ack) == 1'b1) nack++;
    endtask

    logic [31:0]  rdata;
    logic [255:0] rw_nxt, rw_snap;
    int           nack, lat, extra_acks;

    initial begin
        reset = 1; a_req = 0; a_rd = 0; a_addr = '0; a_wr = '0; a_inc = '0;
        b_req = 0; b_rd = 0; b_addr = '0; b_wr = '0; b_inc = '0;
        repeat (3) tick();
        check("reset_ack", 64'(a_ack), 64'd0);
        check("reset_rd_data", 64'(a_rd_data), 64'd0);
        check("reset_rw_regs", 64'(a_rw[255:192] | a_rw[63:0]), 64'd0);
        reset = 0;
        tick();

        // Write reg 3 with a long hold: single ack at T+1, visible at T+2
        bus_access(0, 0, 22'd3, 32'h12345678, 3, rdata, nack, lat, rw_nxt);
        check("wr3_lat", 64'(lat), 64'd1);
        check("wr3_nack", 64'(nack), 64'd1);
        check("wr3_visible", 64'(rw_nxt[3*32 +: 32]), 64'h12345678);
        check("wr3_rd_data_hold", 64'(a_rd_data), 64'd0);
        check("wr3_others", 64'(a_rw & ~(256'hFFFFFFFF << 96)), 64'd0);

        bus_access(0, 1, 22'd3, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("rd3_lat", 64'(lat), 64'd1);
        check("rd3_data", 64'(rdata), 64'h12345678);

        // Boundary RW registers 0 and 7; a write ack leaves reg_rd_data alone
        bus_access(0, 0, 22'd0, 32'hA5A5A5A5, 1, rdata, nack, lat, rw_nxt);
        check("wr0_rd_data_hold", 64'(a_rd_data), 64'h12345678);
        bus_access(0, 0, 22'd7, 32'h0BADF00D, 10, rdata, nack, lat, rw_nxt);
        check("wr7_nack_long_hold", 64'(nack), 64'd1);
        bus_access(0, 1, 22'd0, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("rd0_data", 64'(rdata), 64'hA5A5A5A5);
        bus_access(0, 1, 22'd7, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("rd7_data", 64'(rdata), 64'h0BADF00D);

        // Counter 1: five increments
        a_inc = 8'h02;
        repeat (5) tick();
        a_inc = 8'h00;
        bus_access(0, 1, 22'd9, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("cntr1_five", 64'(rdata), 64'd5);

        // Clear-write with an increment in the ack cycle: clear wins
        a_req = 1; a_rd = 0; a_addr = 22'd9; a_wr = 32'hFFFFFFFF;
        tick();
        check("clr_ack", 64'(a_ack), 64'd1);
        a_inc = 8'h02;
        tick();
        a_inc = 8'h00;
        a_req = 0;
        tick();
        bus_access(0, 1, 22'd9, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("cntr1_cleared", 64'(rdata), 64'd0);

        // Read sampled alongside an increment returns the pre-increment value
        a_inc = 8'h04;
        repeat (3) tick();
        bus_access(0, 1, 22'd10, 32'h0, 1, rdata, nack, lat, rw_nxt);
        a_inc = 8'h00;
        check("cntr2_pre_inc", 64'(rdata), 64'd3);

        bus_access(0, 1, 22'd15, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("cntr7_zero", 64'(rdata), 64'd0);

        // Unmapped addresses
        bus_access(0, 1, 22'd16, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("rd16_marker", 64'(rdata), 64'hDEADBEEF);
        bus_access(0, 1, 22'h3FFFFF, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("rd_top_marker", 64'(rdata), 64'hDEADBEEF);
        check("rd_top_lat", 64'(lat), 64'd1);
        rw_snap = a_rw;
        bus_access(0, 0, 22'h3FFFFF, 32'h55555555, 1, rdata, nack, lat, rw_nxt);
        check("wr_top_nack", 64'(nack), 64'd1);
        check("wr_top_rw_lo", a_rw[127:0] ^ rw_snap[127:0], 64'd0);
        check("wr_top_rw_hi", 64'(a_rw[255:128] != rw_snap[255:128]), 64'd0);

        // Instance B: 4-bit counter saturates after 20 increments
        b_inc = 8'h01;
        repeat (20) tick();
        b_inc = 8'h00;
        bus_access(1, 1, 22'd8, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("b_sat_value", 64'(rdata), 64'h0000000F);
        check("b_sat_lat", 64'(lat), 64'd11);

        // Abort: request dropped after 4 cycles in DELAY
        extra_acks = 0;
        b_req = 1; b_rd = 0; b_addr = 22'd2; b_wr = 32'hCAFEF00D;
        repeat (4) begin tick(); if (b_ack) extra_acks++; end
        b_req = 0;
        repeat (15) begin tick(); if (b_ack) extra_acks++; end
        check("b_abort_no_ack", 64'(extra_acks), 64'd0);
        check("b_abort_no_write", 64'(b_rw[2*32 +: 32]), 64'd0);
        bus_access(1, 0, 22'd2, 32'h11112222, 1, rdata, nack, lat, rw_nxt);
        check("b_after_abort_lat", 64'(lat), 64'd11);
        check("b_after_abort_wr", 64'(rw_nxt[2*32 +: 32]), 64'h11112222);

        // Reset while a write sits in DELAY
        extra_acks = 0;
        b_req = 1; b_rd = 0; b_addr = 22'd5; b_wr = 32'h77777777;
        repeat (3) begin tick(); if (b_ack) extra_acks++; end
        reset = 1; b_req = 0;
        repeat (2) begin tick(); if (b_ack) extra_acks++; end
        reset = 0;
        repeat (15) begin tick(); if (b_ack) extra_acks++; end
        check("b_rst_no_ack", 64'(extra_acks), 64'd0);
        check("b_rst_reg5", 64'(b_rw[5*32 +: 32]), 64'd0);
        check("a_rst_rw_regs", 64'(a_rw != '0), 64'd0);
        bus_access(1, 1, 22'd5, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("b_rst_idle_lat", 64'(lat), 64'd11);
        check("b_rst_reg5_rd", 64'(rdata), 64'd0);
        bus_access(1, 1, 22'd8, 32'h0, 1, rdata, nack, lat, rw_nxt);
        check("b_rst_cntr0", 64'(rdata), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
